if_fetch_queue: RTL and testbench

- Parametrised successor to the pass-through IF stage: owns the PC, issues pipelined instruction-memory requests, and buffers returned instructions in a DEPTH-entry FIFO.
- Presents {pc, pc+4, instruction} to the IF/ID register with a valid/ready handshake.
- Handles redirect (branch/jump/flush), including discarding stale in-flight responses, so instruction-memory latency and ID stalls are decoupled.

---
 rtl/if_fetch_queue.sv | 117 +++++++++++
 tb/tb_if_fetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_fetch_queue: PC owner, pipelined imem requester and IF/ID FIFO      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [XLEN-1:0] imem_resp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] pc_if_id_o,
  output logic [XLEN-1:0] pc_plus_4_if_id_o,
  output logic [XLEN-1:0] instruction_if_id_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic [CW-1:0]   count;
  logic [CW-1:0]   live;
  logic [CW:0]     credit_sum;
  logic            empty;
  logic            req_fire;
  logic            resp_take;
  logic            discard;
  logic            push;
  logic            pop;
  logic [CW-1:0]   inflight_redir;
  logic [XLEN-1:0] redirect_aligned;
  logic [XLEN-1:0] head_pc;

  assign count      = wr_ptr - rd_ptr;
  assign live       = inflight - drop;
  assign credit_sum = {1'b0, count} + {1'b0, live};
  assign empty      = (wr_ptr == rd_ptr);

  // Credit covers both buffered entries and live requests, so a push never finds the FIFO full.
  assign imem_req_valid_o = fetch_en_i & ~redirect_i & (credit_sum < DEPTH_C);
  assign imem_addr_o      = pc;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  // A response with nothing outstanding is ignored entirely.
  assign resp_take = imem_resp_valid_i & (|inflight);
  assign discard   = resp_take & (|drop);
  assign push      = resp_take & ~(|drop) & ~redirect_i;
  assign pop       = id_valid_o & id_ready_i & ~redirect_i;

  assign inflight_redir   = inflight - CW'(resp_take);
  assign redirect_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

  assign id_valid_o          = ~empty;
  assign head_pc             = pc_mem[rd_ptr[AW-1:0]];
  assign pc_if_id_o          = empty ? '0 : head_pc;
  assign pc_plus_4_if_id_o   = empty ? '0 : head_pc + FOUR;
  assign instruction_if_id_o = empty ? '0 : inst_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_i) begin
      // Everything still outstanding after this cycle's response belongs to the old path.
      pc       <= redirect_aligned;
      resp_pc  <= redirect_aligned;
      inflight <= inflight_redir;
      drop     <= inflight_redir;
      rd_ptr   <= wr_ptr;
    end else begin
      if (req_fire) pc <= pc + FOUR;
      if (push) begin
        wr_ptr  <= wr_ptr + CW'(1);
        resp_pc <= resp_pc + FOUR;
      end
      if (pop) rd_ptr <= rd_ptr + CW'(1);
      if (discard) drop <= drop - CW'(1);
      inflight <= inflight + CW'(req_fire) - CW'(resp_take);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr[AW-1:0]]   <= resp_pc;
      inst_mem[wr_ptr[AW-1:0]] <= imem_resp_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// Directed bench for if_fetch_queue with a fixed-latency in-order memory model.
module tb_if_fetch_queue;
  localparam logic [31:0] OFF = 32'h1000_0000;  // instruction word = address + OFF

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid_o;
  logic        id_ready = 1'b0;
  logic [31:0] pc_if_id_o, pc_plus_4_if_id_o, instruction_if_id_o;

  logic        b_fetch = 1'b0, b_req_valid, b_resp_valid = 1'b0, b_id_valid, b_id_ready = 1'b0;
  logic [31:0] b_addr, b_resp_data = '0, b_pc, b_pc4, b_inst;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk = ~clk;

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i(imem_resp_data_i), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .id_valid_o(id_valid_o), .id_ready_i(id_ready),
    .pc_if_id_o(pc_if_id_o), .pc_plus_4_if_id_o(pc_plus_4_if_id_o),
    .instruction_if_id_o(instruction_if_id_o)
  );

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .fetch_en_i(b_fetch),
    .imem_req_valid_o(b_req_valid), .imem_req_ready_i(1'b1),
    .imem_addr_o(b_addr), .imem_resp_valid_i(b_resp_valid),
    .imem_resp_data_i(b_resp_data), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .id_valid_o(b_id_valid), .id_ready_i(b_id_ready),
    .pc_if_id_o(b_pc), .pc_plus_4_if_id_o(b_pc4),
    .instruction_if_id_o(b_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: log any request handshake, advance, then drive whatever response is due.
  task automatic adv();
    #1;
    if (!rst && imem_req_valid_o && imem_req_ready_i) begin
      q_addr.push_back(imem_addr_o);
      q_due.push_back(cyc + lat);
    end
    @(posedge clk);
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end
    @(negedge clk);
    cyc++;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = q_addr.pop_front() + OFF;
      void'(q_due.pop_front());
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    adv();
    adv();
    rst = 1'b0;
    #1;
    chk("rst_id_valid", 32'(id_valid_o), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_pc_out", pc_if_id_o, 32'h0);
    chk("rst_pc4_out", pc_plus_4_if_id_o, 32'h0);
    chk("rst_inst_out", instruction_if_id_o, 32'h0);

    // Streaming: latency 1, ID always ready.
    fetch_en = 1'b1; id_ready = 1'b1; lat = 1;
    #1;
    chk("s_req_valid", 32'(imem_req_valid_o), 32'd1);
    chk("s_addr0", imem_addr_o, 32'h0);
    adv();
    chk("s_addr1", imem_addr_o, 32'h4);
    chk("s_id_empty", 32'(id_valid_o), 32'd0);
    adv();
    chk("s_pc4_first", pc_plus_4_if_id_o, 32'h4);
    chk("s_inst_first", instruction_if_id_o, 32'h1000_0000);
    chk("s_addr2", imem_addr_o, 32'h8);
    for (int i = 0; i < 5; i++) begin
      chk("s_valid", 32'(id_valid_o), 32'd1);
      chk("s_pc", pc_if_id_o, 32'(i * 4));
      adv();
    end
    fetch_en = 1'b0;
    adv(); adv(); adv();
    chk("s_drained", 32'(id_valid_o), 32'd0);

    // Backpressure: latency 2, ID stalled, restart fetch at 0.
    redirect = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0; fetch_en = 1'b1; lat = 2;
    adv();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) adv();
    chk("bp_req_blocked", 32'(imem_req_valid_o), 32'd0);
    adv();
    chk("bp_req_blocked2", 32'(imem_req_valid_o), 32'd0);
    fetch_en = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", 32'(id_valid_o), 32'd1);
      chk("bp_pc", pc_if_id_o, 32'(i * 4));
      chk("bp_inst", instruction_if_id_o, OFF + 32'(i * 4));
      adv();
    end
    chk("bp_empty", 32'(id_valid_o), 32'd0);

    // Redirect to 0x100 with three requests outstanding (latency 3).
    fetch_en = 1'b1; lat = 3;
    adv(); adv(); adv();
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("rd_no_req", 32'(imem_req_valid_o), 32'd0);
    adv();
    redirect = 1'b0;
    #1;
    chk("rd_addr", imem_addr_o, 32'h100);
    chk("rd_req_valid", 32'(imem_req_valid_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rd_stale_dropped", 32'(id_valid_o), 32'd0);
      adv();
    end
    chk("rd_pc", pc_if_id_o, 32'h100);
    chk("rd_inst", instruction_if_id_o, 32'h1000_0100);
    adv();

    // Redirect to 0x203 coinciding with a response and an ID handshake.
    chk("rd2_pre_valid", 32'(id_valid_o), 32'd1);
    chk("rd2_pre_pc", pc_if_id_o, 32'h104);
    chk("rd2_pre_resp", 32'(imem_resp_valid_i), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h203;
    adv();
    redirect = 1'b0;
    #1;
    chk("rd2_empty", 32'(id_valid_o), 32'd0);
    chk("rd2_addr", imem_addr_o, 32'h200);
    chk("rd2_req_valid", 32'(imem_req_valid_o), 32'd1);
    for (int k = 0; k < 10 && !id_valid_o; k++) adv();
    chk("rd2_valid", 32'(id_valid_o), 32'd1);
    chk("rd2_pc", pc_if_id_o, 32'h200);
    chk("rd2_pc4", pc_plus_4_if_id_o, 32'h204);
    chk("rd2_inst", instruction_if_id_o, 32'h1000_0200);

    // Reset with entries buffered and requests outstanding.
    fetch_en = 1'b0;
    for (int i = 0; i < 8; i++) adv();
    redirect = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0; fetch_en = 1'b1; lat = 2;
    adv();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) adv();
    chk("mr_pre_valid", 32'(id_valid_o), 32'd1);
    rst = 1'b1; fetch_en = 1'b0;
    adv();
    rst = 1'b0;
    #1;
    chk("mr_id_valid", 32'(id_valid_o), 32'd0);
    chk("mr_pc_out", pc_if_id_o, 32'h0);
    chk("mr_pc4_out", pc_plus_4_if_id_o, 32'h0);
    chk("mr_inst_out", instruction_if_id_o, 32'h0);
    chk("mr_addr", imem_addr_o, 32'h0);
    chk("mr_req_valid", 32'(imem_req_valid_o), 32'd0);

    // PC wrap on the second instance (RESET_PC = 0xFFFF_FFF8).
    b_fetch = 1'b1;
    #1;
    chk("w_req_valid", 32'(b_req_valid), 32'd1);
    chk("w_addr0", b_addr, 32'hFFFF_FFF8);
    adv();
    chk("w_addr1", b_addr, 32'hFFFF_FFFC);
    adv();
    chk("w_addr2", b_addr, 32'h0);
    adv();
    b_fetch = 1'b0; b_resp_valid = 1'b1; b_resp_data = 32'h0000_0011;
    adv();
    b_resp_data = 32'h0000_0022;
    adv();
    b_resp_valid = 1'b0;
    #1;
    chk("w_head_pc", b_pc, 32'hFFFF_FFF8);
    chk("w_head_pc4", b_pc4, 32'hFFFF_FFFC);
    b_id_ready = 1'b1;
    adv();
    chk("w_pc", b_pc, 32'hFFFF_FFFC);
    chk("w_pc4_wrap", b_pc4, 32'h0);
    chk("w_inst", b_inst, 32'h0000_0022);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
